alu_sequencer: RTL and testbench

Multi-cycle issue controller that sequences the shared 32-bit ALU. It accepts one instruction word at a time over a valid/ready handshake and reads operands from an internal 8×32 register file. It drives the ALU opcode, operands and strobe, captures the result and flag, then retires the instruction. Retirement covers register write-back, the condition flag, and program-counter/jump updates. It sits between the fetch logic and the combinational ALU.

---
 rtl/alu_sequencer_if.sv | 37 +++
 rtl/alu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Groups the instruction handshake and the shared ALU bus of the ALU
//   issue sequencer.
//   Instruction side : instr_valid, instr (to sequencer), instr_ready (from it)
//   ALU side         : alu_op, alu_a, alu_b, alu_value, alu_highlow, alu_f1,
//                      alu_f2, alu_strobe (from sequencer), alu_result,
//                      alu_flag (to sequencer)
//   modport master : the sequencer itself
//   modport slave  : the surroundings (fetch logic and combinational ALU)
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    logic [6:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [15:0] alu_value;
    logic        alu_highlow;
    logic        alu_f1;
    logic        alu_f2;
    logic        alu_strobe;
    logic [31:0] alu_result;
    logic        alu_flag;

    modport master (
        input  instr_valid, instr, alu_result, alu_flag,
        output instr_ready, alu_op, alu_a, alu_b, alu_value,
               alu_highlow, alu_f1, alu_f2, alu_strobe
    );

    modport slave (
        output instr_valid, instr, alu_result, alu_flag,
        input  instr_ready, alu_op, alu_a, alu_b, alu_value,
               alu_highlow, alu_f1, alu_f2, alu_strobe
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle issue controller for the shared 32-bit ALU. Accepts one
//   instruction per IDLE->EXEC->WB round trip, reads operands from an
//   internal 8x32 register file, strobes the ALU in EXEC and retires in WB
//   (register write-back, condition flag, pc / jump).
//   Ports:
//     clock, reset : clock and synchronous active-high reset
//     bus          : instruction handshake + ALU bus (alu_sequencer_if.master)
//     done, err    : one-cycle retire pulse / illegal-opcode pulse (with done)
//     pc           : program counter
//     addrch,naddr : one-cycle jump-taken pulse and its target
module alu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    alu_sequencer_if.master bus,
    output logic            done,
    output logic            err,
    output logic [31:0]     pc,
    output logic            addrch,
    output logic [31:0]     naddr
);
    localparam int NREGS = 8;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [2:0]  rd_q, rd_d;
    logic [31:0] res_q, res_d;
    logic        rflag_q, rflag_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];
    logic        flag_q, flag_d;
    logic        flag_prev_q, flag_prev_d;
    logic [31:0] pc_q, pc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        addrch_q, addrch_d;
    logic [31:0] naddr_q, naddr_d;
    logic [6:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [15:0] alu_value_q, alu_value_d;
    logic        alu_highlow_q, alu_highlow_d;
    logic        alu_f1_q, alu_f1_d;
    logic        alu_f2_q, alu_f2_d;
    logic        alu_strobe_q, alu_strobe_d;
    logic        take_jump;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        res_d         = res_q;
        rflag_d       = rflag_q;
        regs_d        = regs_q;
        flag_d        = flag_q;
        flag_prev_d   = flag_prev_q;
        pc_d          = pc_q;
        // Pulses and ALU drive default to zero; they are set only in the
        // cycle before they must appear because all outputs are registered.
        done_d        = 1'b0;
        err_d         = 1'b0;
        addrch_d      = 1'b0;
        naddr_d       = '0;
        alu_op_d      = '0;
        alu_a_d       = '0;
        alu_b_d       = '0;
        alu_value_d   = '0;
        alu_highlow_d = 1'b0;
        alu_f1_d      = 1'b0;
        alu_f2_d      = 1'b0;
        alu_strobe_d  = 1'b0;
        take_jump     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    op_d          = bus.instr[6:0];
                    rd_d          = bus.instr[9:7];
                    // Operands are read here; strictly serial issue means
                    // no later write can make them stale.
                    alu_op_d      = bus.instr[6:0];
                    alu_a_d       = regs_q[bus.instr[12:10]];
                    alu_b_d       = regs_q[bus.instr[15:13]];
                    alu_value_d   = bus.instr[31:16];
                    alu_highlow_d = (bus.instr[6:0] == 7'd6);
                    alu_f1_d      = flag_q;
                    alu_f2_d      = flag_prev_q;
                    alu_strobe_d  = 1'b1;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d     = bus.alu_result;
                rflag_d   = bus.alu_flag;
                // The flag cannot change before WB, so the conditional jump
                // decision made here equals the flag at the start of WB.
                take_jump = (op_q == 7'd14) || ((op_q == 7'd15) && flag_q);
                done_d    = 1'b1;
                err_d     = (op_q > 7'd15);
                addrch_d  = take_jump;
                naddr_d   = take_jump ? regs_q[7] : 32'd0;
                state_d   = S_WB;
            end
            S_WB: begin
                if (op_q <= 7'd7) begin
                    regs_d[rd_q] = res_q;
                end else if (op_q <= 7'd13) begin
                    flag_prev_d = flag_q;
                    flag_d      = rflag_q;
                end
                pc_d    = addrch_q ? naddr_q : pc_q + 32'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            res_q         <= '0;
            rflag_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            flag_q        <= 1'b0;
            flag_prev_q   <= 1'b0;
            pc_q          <= RESET_PC;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            addrch_q      <= 1'b0;
            naddr_q       <= '0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_value_q   <= '0;
            alu_highlow_q <= 1'b0;
            alu_f1_q      <= 1'b0;
            alu_f2_q      <= 1'b0;
            alu_strobe_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            res_q         <= res_d;
            rflag_q       <= rflag_d;
            regs_q        <= regs_d;
            flag_q        <= flag_d;
            flag_prev_q   <= flag_prev_d;
            pc_q          <= pc_d;
            done_q        <= done_d;
            err_q         <= err_d;
            addrch_q      <= addrch_d;
            naddr_q       <= naddr_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_value_q   <= alu_value_d;
            alu_highlow_q <= alu_highlow_d;
            alu_f1_q      <= alu_f1_d;
            alu_f2_q      <= alu_f2_d;
            alu_strobe_q  <= alu_strobe_d;
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_value   = alu_value_q;
    assign bus.alu_highlow = alu_highlow_q;
    assign bus.alu_f1      = alu_f1_q;
    assign bus.alu_f2      = alu_f2_q;
    assign bus.alu_strobe  = alu_strobe_q;
    assign done            = done_q;
    assign err             = err_q;
    assign pc              = pc_q;
    assign addrch          = addrch_q;
    assign naddr           = naddr_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Drives instructions into alu_sequencer, stands in for the combinational
//   ALU, and checks every EXEC/WB against an instruction-level model whose
//   expectations are queued at issue time.
module tb_alu_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        done, err, addrch;
    logic [31:0] pc, naddr;

    always #5 clock = ~clock;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus.master),
        .done   (done),
        .err    (err),
        .pc     (pc),
        .addrch (addrch),
        .naddr  (naddr)
    );

    // Reference ALU: {flag, result}
    function automatic logic [32:0] alu_fn(input logic [6:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [15:0] imm);
        logic [31:0] r;
        logic        f;
        r = '0;
        f = 1'b0;
        case (op)
            7'd0:        r = a + b;
            7'd1:        r = a - b;
            7'd2:        r = a << b[4:0];
            7'd3:        r = a >> b[4:0];
            7'd4, 7'd7:  r = a;
            7'd5:        r = {a[31:16], imm};
            7'd6:        r = {imm, a[15:0]};
            7'd8:        f = (a == b);
            7'd9:        f = (a < b);
            7'd10:       f = (a > b);
            7'd11:       f = ~|a;
            7'd12:       f = |(a & b);
            7'd13:       f = ~|b;
            default:     r = '0;
        endcase
        return {f, r};
    endfunction

    always_comb begin
        {bus.alu_flag, bus.alu_result} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_value);
    end

    typedef struct {
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic        hl;
        logic        f1;
        logic        f2;
        logic        er;
        logic        jmp;
        logic [31:0] tgt;
        logic [31:0] pc_after;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [8];
    logic        m_flag, m_prev;
    logic [31:0] m_pc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flag = 1'b0;
        m_prev = 1'b0;
        m_pc   = 32'h0;
    endtask

    // Called on a falling edge; returns on the falling edge of the EXEC cycle.
    // instr_valid stays high afterwards so back-to-back issue keeps it asserted.
    task automatic issue(input logic [6:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [15:0] imm);
        exp_t        e;
        logic [32:0] r;
        logic        take;
        int          n;
        e.op  = op;
        e.a   = m_regs[ra];
        e.b   = m_regs[rb];
        e.imm = imm;
        e.hl  = (op == 7'd6);
        e.f1  = m_flag;
        e.f2  = m_prev;
        r     = alu_fn(op, e.a, e.b, imm);
        take  = (op == 7'd14) || ((op == 7'd15) && m_flag);
        e.er  = (op > 7'd15);
        e.jmp = take;
        e.tgt = take ? m_regs[7] : 32'h0;
        if (op <= 7'd7) begin
            m_regs[rd] = r[31:0];
        end else if (op <= 7'd13) begin
            m_prev = m_flag;
            m_flag = r[32];
        end
        m_pc       = take ? m_regs[7] : m_pc + 32'd1;
        e.pc_after = m_pc;
        sb.push_back(e);

        bus.instr       = {imm, rb, ra, rd, op};
        bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (!bus.instr_ready) begin
            chk("accept_timeout", bus.instr_ready, 1);
            finish_up();
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Monitor: operand check during EXEC, retire check in WB, pc one cycle later.
    int          cyc = 0;
    int          prev_acc = -1;
    int          prev_done = -1;
    int          done_cnt = 0;
    bit          pc_pend = 1'b0;
    logic [31:0] pc_exp;

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (reset || !bus.instr_valid) begin
            prev_acc  = -1;
            prev_done = -1;
        end
        if (reset) begin
            pc_pend = 1'b0;
        end else begin
            if (pc_pend) begin
                chk("pc_after_retire", pc, pc_exp);
                chk("done_one_cycle", done, 0);
                pc_pend = 1'b0;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (prev_acc >= 0) chk("accept_spacing", cyc - prev_acc, 3);
                prev_acc = cyc;
            end
            if (!done && (err || addrch)) chk("stray_pulse", {err, addrch}, 0);
            if (bus.alu_strobe) begin
                if (sb.size() == 0) begin
                    chk("strobe_unexpected", bus.alu_strobe, 0);
                end else begin
                    e = sb[0];
                    chk("exec_op", bus.alu_op, e.op);
                    chk("exec_a", bus.alu_a, e.a);
                    chk("exec_b", bus.alu_b, e.b);
                    chk("exec_value", bus.alu_value, e.imm);
                    chk("exec_highlow", bus.alu_highlow, e.hl);
                    chk("exec_f1", bus.alu_f1, e.f1);
                    chk("exec_f2", bus.alu_f2, e.f2);
                    chk("exec_ready_low", bus.instr_ready, 0);
                end
            end
            if (done) begin
                done_cnt++;
                if (prev_done >= 0) chk("done_spacing", cyc - prev_done, 3);
                prev_done = bus.instr_valid ? cyc : -1;
                if (sb.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_err", err, e.er);
                    chk("wb_addrch", addrch, e.jmp);
                    chk("wb_naddr", naddr, e.tgt);
                    chk("wb_ready_low", bus.instr_ready, 0);
                    chk("wb_strobe_low", bus.alu_strobe, 0);
                    chk("wb_alu_a_zero", bus.alu_a, 0);
                    $display("retire op=%0d err=%0b addrch=%0b naddr=%h pc_next=%h",
                             e.op, err, addrch, naddr, e.pc_after);
                    pc_exp  = e.pc_after;
                    pc_pend = 1'b1;
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || pc_pend) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        logic [6:0] rop;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        reset           = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addrch", addrch, 0);
        chk("rst_naddr", naddr, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_strobe", bus.alu_strobe, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_f1", bus.alu_f1, 0);
        reset = 1'b0;
        @(negedge clock);

        // setup: r1=5, r2=3, r3=r1+r2, r4=r1-r2
        issue(7'd5, 3'd1, 3'd1, 3'd0, 16'h0005);
        issue(7'd5, 3'd2, 3'd2, 3'd0, 16'h0003);
        issue(7'd0, 3'd3, 3'd1, 3'd2, 16'h0000);
        issue(7'd1, 3'd4, 3'd1, 3'd2, 16'h0000);
        bus.instr_valid = 1'b0;
        drain();
        chk("pc_after_setup", pc, 32'd4);
        chk("done_count_setup", done_cnt, 4);

        // observe r3/r4 as operands, then build r5 = 0x12345678
        issue(7'd4, 3'd6, 3'd3, 3'd4, 16'h0000);
        issue(7'd5, 3'd5, 3'd5, 3'd0, 16'h5678);
        issue(7'd6, 3'd5, 3'd5, 3'd0, 16'h1234);
        issue(7'd4, 3'd0, 3'd5, 3'd5, 16'h0000);
        // r7=0x40, lt 3<5 then conditional jump (taken)
        issue(7'd5, 3'd7, 3'd7, 3'd0, 16'h0040);
        issue(7'd9, 3'd0, 3'd2, 3'd1, 16'h0000);
        issue(7'd15, 3'd0, 3'd0, 3'd0, 16'h0000);
        bus.instr_valid = 1'b0;
        drain();
        chk("pc_after_jump", pc, 32'h40);
        // gt 3>5 false, conditional jump not taken
        issue(7'd10, 3'd0, 3'd2, 3'd1, 16'h0000);
        issue(7'd15, 3'd0, 3'd0, 3'd0, 16'h0000);
        // illegal opcode, then a move to show regs/flags untouched
        issue(7'h20, 3'd3, 3'd3, 3'd3, 16'hBEEF);
        issue(7'd4, 3'd0, 3'd3, 3'd3, 16'h0000);
        bus.instr_valid = 1'b0;
        drain();
        chk("pc_after_illegal", pc, 32'h44);

        // pc wrap: r7=0xFFFFFFFF, jump, then a non-jump retire
        issue(7'd5, 3'd7, 3'd7, 3'd0, 16'hFFFF);
        issue(7'd6, 3'd7, 3'd7, 3'd0, 16'hFFFF);
        issue(7'd14, 3'd0, 3'd0, 3'd0, 16'h0000);
        bus.instr_valid = 1'b0;
        drain();
        chk("pc_at_max", pc, 32'hFFFF_FFFF);
        issue(7'd4, 3'd1, 3'd7, 3'd7, 16'h0000);
        bus.instr_valid = 1'b0;
        drain();
        chk("pc_wrapped", pc, 32'h0);

        // random mix held back-to-back
        for (int i = 0; i < 24; i++) begin
            rop = 7'($urandom_range(0, 19));
            if (rop > 7'd15) rop = 7'($urandom_range(16, 127));
            issue(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom));
        end
        bus.instr_valid = 1'b0;
        drain();
        chk("pc_after_random", pc, m_pc);

        // reset during EXEC of add r3: discarded, no done
        cnt0 = done_cnt;
        issue(7'd0, 3'd3, 3'd1, 3'd2, 16'h0000);
        #1;
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clock);
        chk("rst_exec_no_done", done_cnt, cnt0);
        chk("rst_exec_ready", bus.instr_ready, 1);
        chk("rst_exec_pc", pc, 32'h0);
        issue(7'd4, 3'd0, 3'd3, 3'd3, 16'h0000);
        bus.instr_valid = 1'b0;
        drain();
        chk("pc_after_rst_move", pc, 32'h1);

        finish_up();
    end
endmodule
